// File: rtl/spi_read_adc.sv
// SPI mode-0 master receive path: chip select, divided serial clock and an
// MSB-first shift-in of one Width-bit frame per start request.
module spi_read_adc #(
  parameter int unsigned Width  = 12,
  parameter int unsigned KWidth = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strr_i,
  input  logic [KWidth-1:0] kmax_i,
  input  logic              miso_i,
  output logic              dclk_o,
  output logic              cs_o,
  output logic [Width-1:0]  data_o,
  output logic              eor_o,
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSLOW,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [KWidth-1:0]   div_q, div_d;
  logic [KWidth-1:0]   kmax_q, kmax_d;
  logic [CntW-1:0]     bit_q, bit_d;
  logic [Width-1:0]    sr_q, sr_d;
  logic [Width-1:0]    data_q, data_d;
  logic                cs_q, cs_d;
  logic                dclk_q, dclk_d;
  logic                eor_q, eor_d;
  logic                busy_q, busy_d;
  logic                active;
  logic                tick;

  // State and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      kmax_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      cs_q    <= 1'b1;
      dclk_q  <= 1'b0;
      eor_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      kmax_q  <= kmax_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      dclk_q  <= dclk_d;
      eor_q   <= eor_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, datapath and output decode
  always_comb begin
    state_d = state_q;
    kmax_d  = kmax_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    active  = (state_q == S_CSLOW) || (state_q == S_HIGH) || (state_q == S_LOW);
    tick    = active && (div_q == kmax_q);

    case (state_q)
      S_IDLE: begin
        if (strr_i) begin
          state_d = S_CSLOW;
          kmax_d  = kmax_i;
          bit_d   = '0;
        end
      end
      S_CSLOW: if (tick) state_d = S_HIGH;
      S_HIGH:  if (tick) state_d = S_LOW;
      S_LOW: begin
        if (tick) state_d = (bit_q == CntW'(Width)) ? S_DONE : S_HIGH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Sample on the edge that raises dclk
    if ((state_d == S_HIGH) && (state_q != S_HIGH)) begin
      sr_d  = {sr_q[Width-2:0], miso_i};
      bit_d = CntW'(bit_q + 1'b1);
    end
    if (state_d == S_DONE) data_d = sr_q;

    if (!active || tick || (state_d != state_q)) div_d = '0;
    else                                          div_d = KWidth'(div_q + 1'b1);

    cs_d   = !((state_d == S_CSLOW) || (state_d == S_HIGH) || (state_d == S_LOW));
    dclk_d = (state_d == S_HIGH);
    eor_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign dclk_o = dclk_q;
  assign cs_o   = cs_q;
  assign data_o = data_q;
  assign eor_o  = eor_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_spi_read_adc.sv
// Directed bench for spi_read_adc with a mode-0 ADC model shifting out queued words.
module tb_spi_read_adc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        strr_i = 1'b0;
  logic [7:0]  kmax_i = 8'd3;
  logic        miso_i;
  logic        dclk_o;
  logic        cs_o;
  logic [11:0] data_o;
  logic        eor_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int rise_last = 0;
  int rise_prev = 0;
  int eor_cnt  = 0;
  bit dclk_prev = 1'b0;
  bit eor_prev  = 1'b0;

  bit          model_en = 1'b0;
  logic        idle_bit = 1'b0;
  logic        adc_bit  = 1'b0;
  logic [11:0] words[$];

  assign miso_i = model_en ? adc_bit : idle_bit;

  spi_read_adc #(.Width(12), .KWidth(8)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .strr_i (strr_i),
    .kmax_i (kmax_i),
    .miso_i (miso_i),
    .dclk_o (dclk_o),
    .cs_o   (cs_o),
    .data_o (data_o),
    .eor_o  (eor_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Edge monitor sampled mid-cycle
  always @(negedge clk_i) begin
    if (dclk_o && !dclk_prev) begin
      rise_cnt++;
      rise_prev = rise_last;
      rise_last = cyc;
    end
    if (eor_o && !eor_prev) eor_cnt++;
    dclk_prev = dclk_o;
    eor_prev  = eor_o;
  end

  // ADC: first bit on CS fall, next bit on each dclk fall
  initial begin : adc_model
    logic [11:0] word;
    int bidx;
    bit armed;
    word = '0;
    bidx = 0;
    armed = 1'b1;
    forever begin
      @(cs_o or dclk_o);
      if (cs_o !== 1'b0) begin
        armed = 1'b1;
      end else if (armed) begin
        if (words.size() > 0) word = words.pop_front();
        else                  word = '0;
        adc_bit = word[11];
        bidx = 1;
        armed = 1'b0;
      end else if (dclk_o === 1'b0) begin
        if (bidx < 12) adc_bit = word[11-bidx];
        bidx++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(output int s);
    @(negedge clk_i);
    strr_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    strr_i = 1'b0;
    s = cyc;
  endtask

  task automatic wait_eor(input int budget, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (eor_o) begin
        at = cyc;
        ok = 1'b1;
        break;
      end
    end
    chk("eor_seen", 32'(ok), 32'd1);
  endtask

  initial begin : stim
    int s, at, at1, r0, e0;

    // Reset and idle behaviour
    #23;
    chk("rst_cs", 32'(cs_o), 32'd1);
    chk("rst_dclk", 32'(dclk_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      idle_bit = ~idle_bit;
      chk("idle_cs", 32'(cs_o), 32'd1);
      chk("idle_dclk", 32'(dclk_o), 32'd0);
      chk("idle_eor", 32'(eor_o), 32'd0);
      chk("idle_busy", 32'(busy_o), 32'd0);
    end
    chk("idle_data", 32'(data_o), 32'd0);
    model_en = 1'b1;

    // Frame 0xA5C at kmax 3
    kmax_i = 8'd3;
    words.push_back(12'hA5C);
    r0 = rise_cnt;
    e0 = eor_cnt;
    start_pulse(s);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_cs_low", 32'(cs_o), 32'd0);
    wait_eor(300, at);
    chk("t1_latency", 32'(at - s), 32'd100);
    chk("t1_data", 32'(data_o), 32'hA5C);
    chk("t1_period", 32'(rise_last - rise_prev), 32'd8);
    chk("t1_cs_done", 32'(cs_o), 32'd1);
    @(negedge clk_i);
    chk("t1_eor_width", 32'(eor_o), 32'd0);
    chk("t1_busy_fall", 32'(busy_o), 32'd0);
    chk("t1_rises", 32'(rise_cnt - r0), 32'd12);
    chk("t1_eor_count", 32'(eor_cnt - e0), 32'd1);

    // Back-to-back frames at kmax 0 with strr held high
    kmax_i = 8'd0;
    words.push_back(12'h001);
    words.push_back(12'h800);
    @(negedge clk_i);
    strr_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    s = cyc;
    wait_eor(100, at1);
    chk("t2_latency", 32'(at1 - s), 32'd25);
    chk("t2_data0", 32'(data_o), 32'h001);
    chk("t2_cs_gap0", 32'(cs_o), 32'd1);
    @(negedge clk_i);
    chk("t2_cs_gap1", 32'(cs_o), 32'd1);
    @(negedge clk_i);
    chk("t2_cs_gap2", 32'(cs_o), 32'd0);
    strr_i = 1'b0;
    chk("t2_data_hold", 32'(data_o), 32'h001);
    wait_eor(100, at);
    chk("t2_spacing", 32'(at - at1), 32'd27);
    chk("t2_data1", 32'(data_o), 32'h800);

    // Restart requests and kmax change while busy are ignored
    kmax_i = 8'd3;
    words.push_back(12'h3C3);
    words.push_back(12'h5A5);
    repeat (3) @(negedge clk_i);
    e0 = eor_cnt;
    start_pulse(s);
    for (int i = 0; i < 40; i++) begin
      strr_i = (i % 5 == 0);
      if (i == 10) kmax_i = 8'd7;
      @(negedge clk_i);
    end
    strr_i = 1'b0;
    wait_eor(200, at);
    chk("t3_latency", 32'(at - s), 32'd100);
    chk("t3_data", 32'(data_o), 32'h3C3);
    chk("t3_period", 32'(rise_last - rise_prev), 32'd8);
    repeat (4) @(negedge clk_i);
    chk("t3_no_requeue", 32'(busy_o), 32'd0);
    chk("t3_eor_count", 32'(eor_cnt - e0), 32'd1);
    start_pulse(s);
    wait_eor(400, at);
    chk("t3_latency_k7", 32'(at - s), 32'd200);
    chk("t3_data_k7", 32'(data_o), 32'h5A5);
    chk("t3_period_k7", 32'(rise_last - rise_prev), 32'd16);

    // Asynchronous reset after five bits
    kmax_i = 8'd1;
    words.push_back(12'h6B9);
    repeat (2) @(negedge clk_i);
    r0 = rise_cnt;
    start_pulse(s);
    for (int i = 0; i < 200 && (rise_cnt - r0) < 5; i++) @(negedge clk_i);
    chk("t4_five_bits", 32'(rise_cnt - r0 >= 5), 32'd1);
    e0 = eor_cnt;
    #1 rst_i = 1'b1;
    #1;
    chk("t4_rst_cs", 32'(cs_o), 32'd1);
    chk("t4_rst_dclk", 32'(dclk_o), 32'd0);
    chk("t4_rst_data", 32'(data_o), 32'd0);
    chk("t4_rst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    chk("t4_no_eor", 32'(eor_cnt - e0), 32'd0);
    chk("t4_cs_idle", 32'(cs_o), 32'd1);
    kmax_i = 8'd2;
    words.push_back(12'hFFF);
    start_pulse(s);
    wait_eor(200, at);
    chk("t4_latency", 32'(at - s), 32'd75);
    chk("t4_data", 32'(data_o), 32'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_read_adc.md
# spi_read_adc

SPI master receive path for the bolometer ADC: on a start strobe it asserts chip select, generates the serial clock from a programmable divider, shifts `Width` bits in from `miso_i` MSB-first, and presents the parallel result with a one-cycle end-of-read pulse. It is the read-side counterpart of the ADC command-write path and shares its `dclk_o`/`cs_o` conventions (idle high CS, idle low clock, SPI mode 0). The clock divider, bit counter, SIPO register and control FSM are all internal to this block.

## Interface
- `Width`, 12, number of bits per read frame (2..32)
- `KWidth`, 8, width of the half-period divider count `kmax_i`
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `strr_i`  in  1  start-read request, sampled in IDLE only
- `kmax_i`  in  KWidth  half-period of `dclk_o` minus one, in `clk_i` cycles
- `miso_i`  in  1  serial data from ADC
- `dclk_o`  out  1  SPI serial clock (idle 0)
- `cs_o`  out  1  chip select, active-low (idle 1)
- `data_o`  out  Width  last completed frame, MSB = first bit received
- `eor_o`  out  1  end-of-read, one `clk_i` cycle pulse
- `busy_o`  out  1  high whenever state is not IDLE

## Operation
- Reset (async, any state): state IDLE; `cs_o`=1, `dclk_o`=0, `eor_o`=0, `busy_o`=0, `data_o`=0, shift register 0, bit counter 0, divider 0.
- Divider: counter counts 0..kmax_r while FSM is out of IDLE/DONE; internal `tick` is high in the cycle count==kmax_r, count wraps to 0; counter forced to 0 on every state change. `kmax_r` latched from `kmax_i` when the frame starts; changes on `kmax_i` mid-frame ignored. `kmax_i`=0 gives a tick every cycle.
- States:
  - IDLE: `cs_o`=1, `dclk_o`=0. `strr_i`=1 -> CSLOW (latch `kmax_i`, clear bit counter).
  - CSLOW: `cs_o`=0, `dclk_o`=0 (CS setup). On tick -> HIGH.
  - HIGH: `cs_o`=0, `dclk_o`=1. On entry edge: shift register <= {sr[Width-2:0], miso_i}, bit counter +1. On tick -> LOW.
  - LOW: `cs_o`=0, `dclk_o`=0. On tick: bit counter == Width -> DONE, else -> HIGH (with sample).
  - DONE: `cs_o`=1, `dclk_o`=0, `data_o` <= shift register, `eor_o`=1 for this single cycle; unconditionally -> IDLE.
- All outputs registered; `miso_i` sampled on the same `clk_i` edge that drives `dclk_o` 0->1.
- `strr_i` outside IDLE ignored (no queuing). `strr_i` held high: new frame starts on the cycle after DONE (one IDLE cycle, `cs_o` high for exactly 2 cycles between frames).
- `data_o` holds its value between DONE states; it never shows partial frames.
- Bit counter width ceil(log2(Width+1)); no wrap within a frame.

## Timing
- `dclk_o` period 2*(kmax_i+1) `clk_i` cycles, 50 % duty.
- CS-low to first rising `dclk_o`: kmax_i+1 cycles; last falling `dclk_o` to CS-high: kmax_i+1 cycles.
- `eor_o` rises (2*Width+1)*(kmax_i+1) cycles after the edge that samples `strr_i`=1; `data_o` valid in the same cycle and after.
- `busy_o` rises one cycle after `strr_i` sampled, falls the cycle after `eor_o`.
- Reset mid-frame: outputs return to reset values immediately (async); `data_o` cleared, no `eor_o`.

## Test plan
- Width=12, kmax_i=3, ADC model drives 0xA5C on falling `dclk_o`, one `strr_i` pulse -> exactly 12 `dclk_o` rises, period 8 cycles, `eor_o` single pulse 100 cycles after start, `data_o`=0xA5C.
- kmax_i=0, pattern 0x001 then 0x800 back-to-back with `strr_i` held high -> `data_o` 0x001 then 0x800, `cs_o` high exactly 2 cycles between frames, 25-cycle frames.
- `strr_i` pulsed repeatedly while `busy_o`=1, and `kmax_i` changed 3->7 mid-frame -> single frame, timing unchanged at kmax 3, next frame uses 7 (eor at 200 cycles).
- `rst_i` asserted after 5 bits -> `cs_o`=1, `dclk_o`=0, `data_o`=0, no `eor_o`; subsequent frame reads 0xFFF correctly.
- Idle checks after reset: `cs_o`=1, `dclk_o`=0, `eor_o`=0, `busy_o`=0 for 50 cycles with `strr_i`=0; `miso_i` toggling has no effect on `data_o`.
